// File: rtl/sar_ctrl_pkg.sv
// Shared state encoding and default timing constants for the per-channel SAR controller.
package sar_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        HOLD,
        REARM
    } sar_state_t;

    localparam int unsigned SAR_SAMPLE_CYCLES_DEFAULT = 2;
    localparam int unsigned SAR_RESET_CYCLES_DEFAULT  = 4;

endpackage

// File: rtl/sar_adc_controller.sv
// Per-channel SAR ADC controller: hit -> sample -> bitwise SAR search -> valid/ready handoff -> CSA re-arm.
module sar_adc_controller
    import sar_ctrl_pkg::*;
#(
    parameter int unsigned ADCBITS       = 10,
    parameter int unsigned SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEFAULT,
    parameter int unsigned RESET_CYCLES  = SAR_RESET_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               hit,
    input  logic               comp,
    output logic               sample,
    output logic               strobe,
    output logic [ADCBITS-1:0] dac_word,
    output logic               csa_reset,
    output logic [ADCBITS-1:0] adc_word,
    output logic               adc_valid,
    input  logic               adc_ready,
    output logic               busy,
    output logic               hit_lost
);

    localparam int unsigned BW  = $clog2(ADCBITS);
    localparam int unsigned SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int unsigned RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    sar_state_t         r_state, w_state_next;
    logic [SCW-1:0]     r_sample_cnt, w_sample_cnt_next;
    logic [RCW-1:0]     r_rst_cnt, w_rst_cnt_next;
    logic [BW-1:0]      r_bit_idx, w_bit_idx_next;
    logic               r_phase, w_phase_next;
    logic [ADCBITS-1:0] r_result, w_result_next;
    logic               r_hit_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_rst_cnt    <= '0;
            r_bit_idx    <= '0;
            r_phase      <= 1'b0;
            r_result     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_sample_cnt <= w_sample_cnt_next;
            r_rst_cnt    <= w_rst_cnt_next;
            r_bit_idx    <= w_bit_idx_next;
            r_phase      <= w_phase_next;
            r_result     <= w_result_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_sample_cnt_next = r_sample_cnt;
        w_rst_cnt_next    = r_rst_cnt;
        w_bit_idx_next    = r_bit_idx;
        w_phase_next      = r_phase;
        w_result_next     = r_result;
        case (r_state)
            IDLE: begin
                if (enable && hit) begin
                    w_state_next      = SAMPLE;
                    w_sample_cnt_next = SCW'(SAMPLE_CYCLES - 1);
                end
            end
            SAMPLE: begin
                if (r_sample_cnt == '0) begin
                    w_state_next   = CONVERT;
                    w_bit_idx_next = BW'(ADCBITS - 1);
                    w_result_next  = '0;
                    w_phase_next   = 1'b0;
                end else begin
                    w_sample_cnt_next = r_sample_cnt - 1'b1;
                end
            end
            CONVERT: begin
                // Comparator decision is taken at the end of the hold phase, a full clock after strobe.
                if (!r_phase) begin
                    w_phase_next = 1'b1;
                end else begin
                    w_phase_next             = 1'b0;
                    w_result_next[r_bit_idx] = comp;
                    if (r_bit_idx == '0) begin
                        w_state_next = HOLD;
                    end else begin
                        w_bit_idx_next = r_bit_idx - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (adc_ready) begin
                    w_state_next   = REARM;
                    w_rst_cnt_next = RCW'(RESET_CYCLES - 1);
                end
            end
            REARM: begin
                if (r_rst_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_rst_cnt_next = r_rst_cnt - 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered views of the current state, so they trail state entry by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample    <= 1'b0;
            strobe    <= 1'b0;
            dac_word  <= '0;
            csa_reset <= 1'b0;
            adc_word  <= '0;
            adc_valid <= 1'b0;
            busy      <= 1'b0;
            hit_lost  <= 1'b0;
            r_hit_d   <= 1'b0;
        end else begin
            sample    <= (r_state == SAMPLE);
            strobe    <= (r_state == CONVERT) && !r_phase;
            csa_reset <= (r_state == REARM);
            adc_valid <= (r_state == HOLD);
            busy      <= (r_state != IDLE);
            r_hit_d   <= hit;
            if ((r_state == CONVERT) && !r_phase) begin
                dac_word <= r_result | (ADCBITS'(1) << r_bit_idx);
            end else if (r_state == HOLD) begin
                dac_word <= '0;
            end
            if (r_state == HOLD) begin
                adc_word <= r_result;
            end
            if ((r_state != IDLE) && hit && !r_hit_d) begin
                hit_lost <= 1'b1;
            end
        end
    end

endmodule
